dct2d_rowcol_sched: RTL and testbench

//  Sequences a single shared 8-point 1-D DCT core (dct8_chen_ts) to perform a full 8x8 2-D DCT.
//  - Row pass: feeds 8 input rows through the core and captures the results in a transpose buffer.
//  - Column pass: feeds the 8 buffered columns through the core and streams the results out.
//  - Sits between the block-fetch stage and the quantiser. The core is instantiated outside this

---
 rtl/dct2d_rowcol_sched_pkg.sv | 19 +
 rtl/dct2d_rowcol_sched_if.sv | 12 +
 rtl/dct2d_rowcol_sched_chk.sv | 22 ++
 rtl/dct2d_rowcol_sched_tbuf.sv | 33 +++
 rtl/dct2d_rowcol_sched.sv | 146 ++++++++++++++
 tb/tb_dct2d_rowcol_sched.sv | 264 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/dct2d_rowcol_sched_pkg.sv
// Shared types and constants for the 8x8 row/column DCT scheduler.
package dct2d_rowcol_sched_pkg;

  localparam int DCT_N = 8;
  localparam int DCT_W = 16;

  typedef logic signed [DCT_W-1:0] dct_sample_t;
  typedef dct_sample_t dct_vec_t [DCT_N];

  // One full row/column on a bus: element i occupies bits [i*DCT_W +: DCT_W].
  typedef logic [DCT_N*DCT_W-1:0] dct_bus_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    COL  = 2'd2
  } dct_sched_state_t;

endpackage

// File: rtl/dct2d_rowcol_sched_if.sv
// Valid/ready stream carrying one 8-sample vector per beat.
interface dct2d_rowcol_sched_if;
  import dct2d_rowcol_sched_pkg::*;

  logic     valid;
  logic     ready;
  dct_bus_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/dct2d_rowcol_sched_chk.sv
// Parameter and protocol checks for the row/column DCT scheduler.
module dct2d_rowcol_sched_chk
  import dct2d_rowcol_sched_pkg::*;
#(
  parameter int W = DCT_W,
  parameter int N = DCT_N
)(
  input logic clk,
  input logic rst_n,
  input logic idle,
  input logic dct_out_valid
);

  if (N != DCT_N || W != DCT_W) begin : g_bad_param
    $error("dct2d_rowcol_sched: only N=8, W=16 are supported");
  end

  // The core has nothing legitimately in flight while the scheduler is idle.
  a_no_core_out_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
    !(idle && dct_out_valid));

endmodule

// File: rtl/dct2d_rowcol_sched_tbuf.sv
// 8x8 transpose buffer: rows written from the row pass, columns read for the column pass.
// Contents are deliberately not reset; every row is rewritten before it is read.
module dct2d_rowcol_sched_tbuf
  import dct2d_rowcol_sched_pkg::*;
(
  input  logic     clk,
  input  logic     wr_en,
  input  logic [2:0] wr_row,
  input  dct_bus_t wr_data,
  input  logic [2:0] rd_col,
  output dct_bus_t rd_data
);

  dct_vec_t mem_r [DCT_N];

  // Store one row-pass result into buffer row wr_row.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < DCT_N; c++) begin
        mem_r[wr_row][c] <= wr_data[c*DCT_W +: DCT_W];
      end
    end
  end

  // Gather column rd_col: element r comes from buffer row r.
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < DCT_N; r++) begin
      rd_data[r*DCT_W +: DCT_W] = mem_r[r][rd_col];
    end
  end

endmodule

// File: rtl/dct2d_rowcol_sched.sv
// Drives one shared 8-point DCT core twice per block: a row pass into the transpose
// buffer, then a column pass whose results stream straight out with no extra latency.
module dct2d_rowcol_sched
  import dct2d_rowcol_sched_pkg::*;
#(
  parameter int W = DCT_W,
  parameter int N = DCT_N
)(
  input  logic                         clk,
  input  logic                         rst_n,
  dct2d_rowcol_sched_if.slave          in_if,
  dct2d_rowcol_sched_if.master         out_if,
  output logic                         out_last,
  dct2d_rowcol_sched_if.master         dct_in_if,
  dct2d_rowcol_sched_if.slave          dct_out_if,
  output logic                         busy
);

  dct_sched_state_t state_r;
  logic [3:0]       iss_r;
  logic [3:0]       cap_r;
  logic [3:0]       emit_r;
  logic             busy_r;

  logic     iss_open_s;
  logic     in_ready_s;
  logic     dct_in_valid_s;
  dct_bus_t dct_in_data_s;
  logic     dct_out_ready_s;
  logic     out_valid_s;
  logic     out_last_s;
  dct_bus_t rd_data_s;

  assign iss_open_s = (iss_r < 4'd8);

  // Handshake steering: which stream feeds the core and where its results go.
  always_comb begin
    in_ready_s      = 1'b0;
    dct_in_valid_s  = 1'b0;
    dct_in_data_s   = in_if.data;
    dct_out_ready_s = 1'b1;
    out_valid_s     = 1'b0;
    out_last_s      = 1'b0;
    case (state_r)
      ROW: begin
        in_ready_s     = dct_in_if.ready & iss_open_s;
        dct_in_valid_s = in_if.valid & iss_open_s;
        dct_in_data_s  = in_if.data;
      end
      COL: begin
        dct_in_valid_s  = iss_open_s;
        dct_in_data_s   = rd_data_s;
        out_valid_s     = dct_out_if.valid;
        dct_out_ready_s = out_if.ready;
        out_last_s      = dct_out_if.valid & (emit_r == 4'd7);
      end
      default: begin
        dct_out_ready_s = 1'b1;
      end
    endcase
  end

  // Sequencer: issue/capture/emit counters and the IDLE->ROW->COL->IDLE walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      iss_r   <= 4'd0;
      cap_r   <= 4'd0;
      emit_r  <= 4'd0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= ROW;
          busy_r  <= 1'b1;
          iss_r   <= 4'd0;
          cap_r   <= 4'd0;
          emit_r  <= 4'd0;
        end
        ROW: begin
          if (dct_in_valid_s && dct_in_if.ready) begin
            iss_r <= iss_r + 4'd1;
          end
          if (dct_out_if.valid) begin
            if (cap_r == 4'd7) begin
              state_r <= COL;
              iss_r   <= 4'd0;
              cap_r   <= 4'd0;
            end else begin
              cap_r <= cap_r + 4'd1;
            end
          end
        end
        COL: begin
          if (dct_in_valid_s && dct_in_if.ready) begin
            iss_r <= iss_r + 4'd1;
          end
          if (out_valid_s && out_if.ready) begin
            if (emit_r == 4'd7) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              iss_r   <= 4'd0;
              cap_r   <= 4'd0;
              emit_r  <= 4'd0;
            end else begin
              emit_r <= emit_r + 4'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          iss_r   <= 4'd0;
          cap_r   <= 4'd0;
          emit_r  <= 4'd0;
        end
      endcase
    end
  end

  dct2d_rowcol_sched_tbuf u_tbuf (
    .clk     (clk),
    .wr_en   ((state_r == ROW) && dct_out_if.valid),
    .wr_row  (cap_r[2:0]),
    .wr_data (dct_out_if.data),
    .rd_col  (iss_r[2:0]),
    .rd_data (rd_data_s)
  );

  dct2d_rowcol_sched_chk #(.W(W), .N(N)) u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .idle          (state_r == IDLE),
    .dct_out_valid (dct_out_if.valid)
  );

  assign in_if.ready     = in_ready_s;
  assign dct_in_if.valid = dct_in_valid_s;
  assign dct_in_if.data  = dct_in_data_s;
  assign dct_out_if.ready = dct_out_ready_s;
  assign out_if.valid    = out_valid_s;
  assign out_if.data     = dct_out_if.data;
  assign out_last        = out_last_s;
  assign busy            = busy_r;

endmodule

// File: tb/tb_dct2d_rowcol_sched.sv
// Bench for dct2d_rowcol_sched: identity stub core, block-level expected-output model.
module tb_dct2d_rowcol_sched;
  import dct2d_rowcol_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dct2d_rowcol_sched_if in_if ();
  dct2d_rowcol_sched_if out_if ();
  dct2d_rowcol_sched_if dci_if ();
  dct2d_rowcol_sched_if dco_if ();
  logic out_last;
  logic busy;

  dct2d_rowcol_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (in_if),
    .out_if     (out_if),
    .out_last   (out_last),
    .dct_in_if  (dci_if),
    .dct_out_if (dco_if),
    .busy       (busy)
  );

  typedef struct { dct_bus_t d; int t; } core_ent_t;
  typedef enum {M_IDLE, M_ROW, M_COL} mph_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  dct_bus_t  src_q [$];   // rows still to be offered
  dct_bus_t  exp_q [$];   // transposed columns the block must produce
  core_ent_t core_q [$];  // stub core pipeline
  dct_bus_t  beat_log [$];

  int lat = 3;
  bit toggle_in = 1'b0;
  bit stall_core = 1'b0;
  bit hold_out = 1'b0;

  mph_t ph = M_IDLE;
  int rows = 0, caps = 0, iss = 0, emits = 0, col_cyc = 0;
  int last_cnt = 0, low_run = 0, last_gap = -1;

  function automatic dct_bus_t row_vec(int base, int r);
    dct_bus_t v;
    for (int c = 0; c < DCT_N; c++) v[c*DCT_W +: DCT_W] = dct_sample_t'(base + r*8 + c);
    return v;
  endfunction

  function automatic dct_bus_t col_vec(int base, int k);
    dct_bus_t v;
    for (int j = 0; j < DCT_N; j++) v[j*DCT_W +: DCT_W] = dct_sample_t'(base + j*8 + k);
    return v;
  endfunction

  function automatic int elem(dct_bus_t b, int i);
    dct_sample_t s;
    s = b[i*DCT_W +: DCT_W];
    return int'(s);
  endfunction

  task automatic chk1(string nm, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chkd(string nm, dct_bus_t act, dct_bus_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chki(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_block(int base);
    for (int r = 0; r < DCT_N; r++) src_q.push_back(row_vec(base, r));
    for (int k = 0; k < DCT_N; k++) exp_q.push_back(col_vec(base, k));
  endtask

  task automatic drive();
    in_if.valid  = (src_q.size() > 0) && (!toggle_in || (cyc % 2 == 0));
    in_if.data   = (src_q.size() > 0) ? src_q[0] : '0;
    dci_if.ready = !(stall_core && (cyc % 3 == 0));
    dco_if.valid = (core_q.size() > 0) && (core_q[0].t <= cyc);
    dco_if.data  = (core_q.size() > 0) ? core_q[0].d : '0;
    out_if.ready = !(hold_out && ph == M_COL && col_cyc >= 2 && col_cyc <= 5);
  endtask

  task automatic sample();
    bit in_hs, ci_hs, co_hs, o_hs;
    bit e_ci_valid;
    if (!rst_n) begin
      chk1("rst_in_ready", in_if.ready, 1'b0);
      chk1("rst_out_valid", out_if.valid, 1'b0);
      chk1("rst_out_last", out_last, 1'b0);
      chk1("rst_dct_in_valid", dci_if.valid, 1'b0);
      chk1("rst_dct_out_ready", dco_if.ready, 1'b1);
      chk1("rst_busy", busy, 1'b0);
      return;
    end
    e_ci_valid = (ph == M_ROW) ? (in_if.valid && rows < 8) : ((ph == M_COL) && iss < 8);
    chk1("in_ready", in_if.ready, (ph == M_ROW) && rows < 8 && dci_if.ready);
    chk1("dct_in_valid", dci_if.valid, e_ci_valid);
    chk1("dct_out_ready", dco_if.ready, (ph == M_COL) ? out_if.ready : 1'b1);
    chk1("out_valid", out_if.valid, (ph == M_COL) && dco_if.valid);
    chk1("out_last", out_last, (ph == M_COL) && dco_if.valid && emits == 7);
    chk1("busy", busy, ph != M_IDLE);

    in_hs = in_if.valid && in_if.ready;
    ci_hs = dci_if.valid && dci_if.ready;
    co_hs = dco_if.valid && dco_if.ready;
    o_hs  = out_if.valid && out_if.ready;

    if (in_hs && src_q.size() > 0) void'(src_q.pop_front());
    if (ci_hs) core_q.push_back('{d: dci_if.data, t: cyc + lat});
    if (co_hs && core_q.size() > 0) void'(core_q.pop_front());
    if (o_hs) begin
      beat_log.push_back(out_if.data);
      if (out_last) last_cnt++;
      if (exp_q.size() == 0) begin
        chkd("out_col_unexpected", out_if.data, '0);
      end else begin
        chkd("out_col", out_if.data, exp_q.pop_front());
      end
    end

    if (!busy) low_run++;
    else begin
      if (low_run > 0) last_gap = low_run;
      low_run = 0;
    end

    case (ph)
      M_IDLE: begin ph = M_ROW; rows = 0; caps = 0; end
      M_ROW: begin
        if (in_hs) rows++;
        if (co_hs) begin
          caps++;
          if (caps == 8) begin ph = M_COL; iss = 0; emits = 0; col_cyc = -1; end
        end
      end
      default: begin
        if (ci_hs) iss++;
        if (o_hs) begin
          emits++;
          if (emits == 8) ph = M_IDLE;
        end
      end
    endcase
    if (ph == M_COL) col_cyc++;
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_done(string nm, int budget);
    int n = 0;
    while ((exp_q.size() > 0 || ph != M_ROW) && n < budget) begin step(); n++; end
    chki({nm, "_outstanding"}, exp_q.size(), 0);
  endtask

  task automatic clear_model();
    src_q.delete(); exp_q.delete(); core_q.delete();
    ph = M_IDLE; rows = 0; caps = 0; iss = 0; emits = 0;
  endtask

  initial begin
    dct_bus_t b;
    int n;
    rst_n = 1'b0;
    drive();
    @(posedge clk); #1;
    step(); step();
    rst_n = 1'b1;
    step(); step();

    // 1: basic block, all handshakes free-running
    beat_log.delete(); last_cnt = 0;
    push_block(0);
    run_done("t1", 200);
    chki("t1_beats", beat_log.size(), 8);
    chki("t1_last_cnt", last_cnt, 1);
    if (beat_log.size() == 8) begin
      b = beat_log[0]; chki("t1_b0_e1", elem(b, 1), 8);
      b = beat_log[3]; chki("t1_b3_e5", elem(b, 5), 43);
      b = beat_log[7]; chki("t1_b7_e7", elem(b, 7), 63);
    end

    // 2: in_valid toggling
    toggle_in = 1'b1;
    push_block(0);
    run_done("t2", 300);
    toggle_in = 1'b0;

    // 3: out_ready low for COL cycles 2..5
    hold_out = 1'b1; beat_log.delete();
    push_block(0);
    run_done("t3", 300);
    chki("t3_beats", beat_log.size(), 8);
    hold_out = 1'b0;

    // 4: core stalls every 3rd cycle, latency 1
    stall_core = 1'b1; lat = 1;
    push_block(0);
    run_done("t4", 300);
    stall_core = 1'b0; lat = 3;

    // 5: back-to-back blocks, busy gap of exactly one cycle
    beat_log.delete(); last_cnt = 0; last_gap = -1;
    push_block(0);
    push_block(100);
    run_done("t5", 400);
    chki("t5_beats", beat_log.size(), 16);
    chki("t5_last_cnt", last_cnt, 2);
    chki("t5_busy_gap", last_gap, 1);
    if (beat_log.size() == 16) begin
      b = beat_log[8];  chki("t5_b8_e0", elem(b, 0), 100);
      b = beat_log[15]; chki("t5_b15_e7", elem(b, 7), 163);
    end

    // 6: reset after three column-pass beats, then a fresh block
    push_block(0);
    n = 0;
    while (!(ph == M_COL && emits == 3) && n < 200) begin step(); n++; end
    chki("t6_reached_col3", emits, 3);
    rst_n = 1'b0;
    clear_model();
    step(); step();
    rst_n = 1'b1;
    beat_log.delete();
    push_block(50);
    run_done("t6", 200);
    chki("t6_beats", beat_log.size(), 8);
    if (beat_log.size() == 8) begin
      b = beat_log[0]; chki("t6_b0_e0", elem(b, 0), 50);
      b = beat_log[2]; chki("t6_b2_e4", elem(b, 4), 84);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
